jt12_fir_mc: RTL and testbench
==============================

// Module: jt12_fir_mc
// PURPOSE
// Parametrised, multi-channel symmetric FIR for the JT12 audio output path. Per
// sample strobe it stores one word per channel in a circular history buffer and runs
// a single time-shared MAC over folded tap pairs. It emits all channels together
// with a one-cycle valid. Coefficients are run-time programmable, not fixed in RTL.
// PARAMETERS
// DW       9   input sample width, signed
// CW       9   coefficient width, signed
// STAGES   73  filter length; odd, >=3 (elaboration error otherwise)
// CH       2   channel count; channel c occupies din/dout slice c
// OW       20  output width, signed, saturated
// SHIFT    0   arithmetic right shift applied to accumulator before saturation
// PORTS
// clk        in   1          single clock; all state changes on rising edge
// rst_n      in   1          asynchronous, active-low reset
// sample     in   1          input strobe, one cycle; din valid on this cycle
// din        in   CH*DW      packed signed inputs, ch0 in LSBs
// coef_we    in   1          coefficient write enable
// coef_addr  in   clog2(H+1) coefficient index, H=(STAGES-1)/2
// coef_data  in   CW         signed coefficient value
// ovf_clr    in   1          clears sticky flags ovf and coef_drop
// busy       out  1          high while a computation is in progress
// dout       out  CH*OW      packed signed filtered outputs, held between updates
// sample_out out  1          one-cycle pulse: dout just updated
// ovf        out  1          sticky: a sample strobe arrived while busy
// coef_drop  out  1          sticky: a coef write arrived while busy
// BEHAVIOUR
// - Reset (rst_n low, async): history zeroed, wr_ptr=0, coefficients zeroed, FSM=IDLE.
//   Outputs: busy=0, dout=0, sample_out=0, ovf=0, coef_drop=0. Reset mid-RUN aborts.
//   No output pulse is produced for the aborted sample.
// - History: CH x STAGES words. x_c[k] = buf_c[(wr_ptr-k) mod STAGES], k=0 newest.
//   wr_ptr wraps STAGES-1 -> 0.
// - FSM IDLE: sample=1 at edge T0 writes din into buf_c[wr_ptr+1 mod STAGES] for all c.
//   The same edge advances wr_ptr, clears all accumulators and sets busy=1.
//   The FSM goes to RUN with ch=0, k=0.
// - FSM RUN: one MAC step per edge.
//   For k<H: acc_ch += coef[k]*(x_ch[k]+x_ch[STAGES-1-k]), with a DW+1 bit pre-add.
//   For k==H: acc_ch += coef[H]*x_ch[H]. After k==H, k=0 and ch++.
//   After the last channel the FSM goes to DONE.
// - Accumulator is full precision: DW+1+CW+clog2(H+1) bits. No overflow inside the MAC.
// - FSM DONE: one edge. dout_c = sat_OW(acc_c >>> SHIFT), sample_out=1 and busy=0.
//   The FSM returns to IDLE. sample_out is low on every other cycle.
// - Latency: sample_out is high after edge T0 + CH*(H+1) + 1. Defaults: 75 cycles.
//   Minimum strobe spacing is CH*(H+1)+2 cycles.
// - sample while busy (RUN or DONE): the strobe is ignored and ovf is set.
//   History and the running result are unaffected.
// - Coefficient write in IDLE: coef[coef_addr] <= coef_data.
//   If coef_addr>H the write is ignored and no flag is set.
// - Coefficient write while busy: the write is ignored and coef_drop is set.
// - Write and sample on the same IDLE edge: the write applies first.
//   The run that starts uses the new value.
// - ovf_clr clears ovf and coef_drop. A set condition on the same edge wins.
// - Saturation: values above 2^(OW-1)-1 clamp to it; values below -2^(OW-1) clamp to it.
// TESTING
// - Impulse: coef[k]=k+1 (k=0..36); ch0 gets 100 then zeros, ch1 zeros.
//   -> ch0 outputs 100,200,..,3700,3600,..,100 over 73 samples, then 0; ch1 always 0.
// - Latency/handshake: a single strobe at cycle 0 -> busy high cycles 1..74.
//   -> sample_out high exactly once, visible at cycle 75.
// - Saturation: all coef=255, din all channels=255 repeated 73 times -> dout=524287.
//   With din=-256 -> dout=-524288.
// - Overrun: strobe, then a second strobe 10 cycles later -> ovf=1.
//   -> The first result is unchanged and the second sample is absent from history.
//   ovf_clr -> ovf=0.
// - Coef write during RUN -> coef_drop=1 and the coefficient is unchanged.
//   coef_addr=40 in IDLE -> no effect.
// - Reset mid-RUN at cycle 20 -> all outputs 0 immediately; no sample_out.
//   Next impulse behaves as from power-up.
// - Wrap: 300 random samples with CH=3, STAGES=15 -> bit-exact vs reference model.

Source files
------------

// File: rtl/jt12_fir_mc.sv
// Multi-channel symmetric FIR: circular history per channel, one shared MAC over
// folded tap pairs, run-time programmable coefficients, saturated outputs.

module jt12_fir_mc_lane #(
  parameter int ACCW  = 25,
  parameter int PRW   = 19,
  parameter int OW    = 20,
  parameter int SHIFT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  ld,
  input  logic signed [PRW-1:0] prod,
  output logic signed [OW-1:0]  dout
);
  localparam int EW = (ACCW > OW) ? ACCW : OW;
  localparam logic signed [EW-1:0] MAXV = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [ACCW-1:0] acc;
  logic signed [EW-1:0]   sh;

  assign sh = EW'(acc) >>> SHIFT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      dout <= '0;
    end else begin
      if (clr)     acc <= '0;
      else if (en) acc <= acc + ACCW'(prod);
      if (ld)
        dout <= (sh > MAXV) ? MAXV[OW-1:0] :
                (sh < MINV) ? MINV[OW-1:0] : sh[OW-1:0];
    end
  end
endmodule

module jt12_fir_mc #(
  parameter  int DW     = 9,
  parameter  int CW     = 9,
  parameter  int STAGES = 73,
  parameter  int CH     = 2,
  parameter  int OW     = 20,
  parameter  int SHIFT  = 0,
  localparam int H      = (STAGES-1)/2,
  localparam int AW     = $clog2(H+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample,
  input  logic [CH*DW-1:0]     din,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic [CW-1:0]        coef_data,
  input  logic                 ovf_clr,
  output logic                 busy,
  output logic [CH*OW-1:0]     dout,
  output logic                 sample_out,
  output logic                 ovf,
  output logic                 coef_drop
);
  localparam int PW   = $clog2(STAGES);
  localparam int CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int PRW  = DW+1+CW;
  localparam int ACCW = DW+1+CW+AW;

  generate
    if ((STAGES % 2) == 0 || STAGES < 3) begin : g_bad_stages
      $error("jt12_fir_mc: STAGES must be odd and >= 3");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [AW-1:0]                   k;
  logic [CHW-1:0]                  ch;
  logic [PW-1:0]                   wr_ptr, wr_nxt;
  logic [CH-1:0][STAGES-1:0][DW-1:0] hist;
  logic [H:0][CW-1:0]              coef;
  logic                            start, mac_en, done, last_k, last_ch;

  assign start   = (state == IDLE) && sample;
  assign last_k  = (k == AW'(H));
  assign last_ch = (ch == CHW'(CH-1));
  assign wr_nxt  = (wr_ptr == PW'(STAGES-1)) ? '0 : wr_ptr + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample) state_nxt = RUN;
      RUN:     if (last_k && last_ch) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    mac_en = (state == RUN);
    done   = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k  <= '0;
      ch <= '0;
    end else if (start) begin
      k  <= '0;
      ch <= '0;
    end else if (mac_en) begin
      if (last_k) begin
        k  <= '0;
        ch <= ch + CHW'(1);
      end else begin
        k  <= k + AW'(1);
      end
    end
  end

  // The newest word goes one slot ahead of the pointer, so after the edge x[0] sits at wr_ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= '0;
      wr_ptr <= '0;
    end else if (start) begin
      wr_ptr <= wr_nxt;
      for (int c = 0; c < CH; c++) hist[c][wr_nxt] <= din[c*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      coef <= '0;
    else if (coef_we && !busy && coef_addr <= AW'(H))
      coef[coef_addr] <= coef_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_out <= 1'b0;
      ovf        <= 1'b0;
      coef_drop  <= 1'b0;
    end else begin
      sample_out <= done;
      if (sample && busy)       ovf <= 1'b1;
      else if (ovf_clr)         ovf <= 1'b0;
      if (coef_we && busy)      coef_drop <= 1'b1;
      else if (ovf_clr)         coef_drop <= 1'b0;
    end
  end

  // Tap pair (k, STAGES-1-k) maps to slots wr_ptr-k and wr_ptr+1+k modulo STAGES.
  logic [PW:0]            ia_w, ib_w;
  logic [PW-1:0]          ia, ib;
  logic signed [DW-1:0]   xa, xb;
  logic signed [DW:0]     pre;
  logic signed [CW-1:0]   cf;
  logic signed [PRW-1:0]  prod;

  assign ia_w = {1'b0, wr_ptr} + (PW+1)'(STAGES) - (PW+1)'(k);
  assign ib_w = {1'b0, wr_ptr} + (PW+1)'(k) + (PW+1)'(1);
  assign ia   = (ia_w >= (PW+1)'(STAGES)) ? PW'(ia_w - (PW+1)'(STAGES)) : PW'(ia_w);
  assign ib   = (ib_w >= (PW+1)'(STAGES)) ? PW'(ib_w - (PW+1)'(STAGES)) : PW'(ib_w);
  assign xa   = hist[ch][ia];
  assign xb   = hist[ch][ib];
  assign pre  = last_k ? {xa[DW-1], xa} : {xa[DW-1], xa} + {xb[DW-1], xb};
  assign cf   = coef[k];
  assign prod = PRW'(cf) * PRW'(pre);

  logic [CH-1:0][OW-1:0] dout_l;
  assign dout = dout_l;

  genvar c;
  generate
    for (c = 0; c < CH; c++) begin : g_lane
      jt12_fir_mc_lane #(.ACCW(ACCW), .PRW(PRW), .OW(OW), .SHIFT(SHIFT)) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (start),
        .en   (mac_en && (ch == CHW'(c))),
        .ld   (done),
        .prod (prod),
        .dout (dout_l[c])
      );
    end
  endgenerate
endmodule

// File: tb/tb_jt12_fir_mc.sv
// Bench for jt12_fir_mc: default 2-channel/73-tap instance plus a 3-channel/15-tap
// instance, checked against a direct-form (unfolded) convolution model.

module tb_jt12_fir_mc;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        s0 = 0, cwe0 = 0, oclr0 = 0;
  logic [17:0] din0 = '0;
  logic [5:0]  caddr0 = '0;
  logic [8:0]  cdata0 = '0;
  logic        busy0, so0, ovf0, cd0;
  logic [39:0] dout0;

  logic        s1 = 0, cwe1 = 0, oclr1 = 0;
  logic [26:0] din1 = '0;
  logic [2:0]  caddr1 = '0;
  logic [8:0]  cdata1 = '0;
  logic        busy1, so1, ovf1, cd1;
  logic [59:0] dout1;

  jt12_fir_mc dut0 (
    .clk(clk), .rst_n(rst_n), .sample(s0), .din(din0), .coef_we(cwe0),
    .coef_addr(caddr0), .coef_data(cdata0), .ovf_clr(oclr0), .busy(busy0),
    .dout(dout0), .sample_out(so0), .ovf(ovf0), .coef_drop(cd0));

  jt12_fir_mc #(.CH(3), .STAGES(15)) dut1 (
    .clk(clk), .rst_n(rst_n), .sample(s1), .din(din1), .coef_we(cwe1),
    .coef_addr(caddr1), .coef_data(cdata1), .ovf_clr(oclr1), .busy(busy1),
    .dout(dout1), .sample_out(so1), .ovf(ovf1), .coef_drop(cd1));

  int checks = 0, errors = 0;
  int r0, r1, r2;
  int x0[2][73];
  int c0[37];
  int x1[3][15];
  int c1[8];

  typedef struct {int d0; int d1; int e0; int e1;} vec_t;
  vec_t tbl[80];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic int sat(input longint v);
    if (v > 524287)  return 524287;
    if (v < -524288) return -524288;
    return int'(v);
  endfunction

  // Direct-form model: full tap vector h[i] mirrors the programmed half.
  function automatic int ref0(input int c);
    longint s = 0;
    for (int i = 0; i < 73; i++) s += longint'(c0[(i <= 36) ? i : 72 - i]) * x0[c][i];
    return sat(s);
  endfunction

  function automatic int ref1(input int c);
    longint s = 0;
    for (int i = 0; i < 15; i++) s += longint'(c1[(i <= 7) ? i : 14 - i]) * x1[c][i];
    return sat(s);
  endfunction

  function automatic int rnd9();
    return int'($urandom_range(511)) - 256;
  endfunction

  task automatic clr_model0;
    for (int c = 0; c < 2; c++) for (int i = 0; i < 73; i++) x0[c][i] = 0;
    for (int i = 0; i < 37; i++) c0[i] = 0;
  endtask

  task automatic push0(input int a, input int b);
    for (int i = 72; i > 0; i--) begin x0[0][i] = x0[0][i-1]; x0[1][i] = x0[1][i-1]; end
    x0[0][0] = a; x0[1][0] = b;
  endtask

  task automatic wc0(input int addr, input int data);
    cwe0 = 1; caddr0 = 6'(addr); cdata0 = 9'(data);
    tick;
    cwe0 = 0;
    if (addr <= 36) c0[addr] = data;
  endtask

  task automatic start0(input int a, input int b);
    din0 = {9'(b), 9'(a)}; s0 = 1;
    tick;
    s0 = 0;
    push0(a, b);
  endtask

  task automatic finish0(input string nm, input int n0);
    int n = n0;
    while (!so0 && n < 300) begin tick; n++; end
    chk({nm, "_lat"}, n, 75);
    r0 = int'($signed(dout0[19:0]));
    r1 = int'($signed(dout0[39:20]));
  endtask

  task automatic samp0(input string nm, input int a, input int b);
    start0(a, b);
    finish0(nm, 0);
    chk({nm, "_c0"}, r0, ref0(0));
    chk({nm, "_c1"}, r1, ref0(1));
  endtask

  task automatic wc1(input int addr, input int data);
    cwe1 = 1; caddr1 = 3'(addr); cdata1 = 9'(data);
    tick;
    cwe1 = 0;
    c1[addr] = data;
  endtask

  task automatic samp1(input int a, input int b, input int d);
    int n = 0;
    din1 = {9'(d), 9'(b), 9'(a)}; s1 = 1;
    tick;
    s1 = 0;
    for (int i = 14; i > 0; i--)
      for (int c = 0; c < 3; c++) x1[c][i] = x1[c][i-1];
    x1[0][0] = a; x1[1][0] = b; x1[2][0] = d;
    while (!so1 && n < 100) begin tick; n++; end
    chk("w_lat", n, 25);
    for (int c = 0; c < 3; c++)
      chk("w_out", int'($signed(dout1[c*20 +: 20])), ref1(c));
  endtask

  initial begin
    int bc, sc, v, a;
    clr_model0();
    for (int n = 0; n < 80; n++) begin
      tbl[n].d0 = (n == 0) ? 100 : 0;
      tbl[n].d1 = 0;
      tbl[n].e0 = (n < 73) ? 100 * (((n <= 36) ? n : 72 - n) + 1) : 0;
      tbl[n].e1 = 0;
    end

    tick; tick;
    chk("rst_busy", busy0, 0);
    chk("rst_dout", longint'(dout0), 0);
    chk("rst_so", so0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_cd", cd0, 0);
    rst_n = 1;
    tick;

    // Impulse response through the table.
    for (int k = 0; k < 37; k++) wc0(k, k + 1);
    for (int n = 0; n < 80; n++) begin
      start0(tbl[n].d0, tbl[n].d1);
      finish0("imp", 0);
      chk("imp_c0", r0, tbl[n].e0);
      chk("imp_c1", r1, tbl[n].e1);
    end

    // Busy / sample_out timing relative to the accepting edge.
    start0(0, 0);
    bc = busy0; sc = so0;
    chk("hs_busy0", busy0, 1);
    for (int n = 1; n <= 76; n++) begin
      tick;
      bc += busy0; sc += so0;
      if (n == 74) chk("hs_busy74", busy0, 1);
      if (n == 75) begin chk("hs_so75", so0, 1); chk("hs_busy75", busy0, 0); end
    end
    chk("hs_busycnt", bc, 75);
    chk("hs_socnt", sc, 1);

    // Random coefficients and samples.
    for (int k = 0; k < 37; k++) wc0(k, rnd9());
    for (int n = 0; n < 20; n++) samp0("rnd", rnd9(), rnd9());

    // Coefficient write and strobe on the same edge: the run sees the new value.
    v = (c0[0] > 0) ? -c0[0] : 200;
    a = 1 + int'($urandom_range(254));
    cwe0 = 1; caddr0 = 0; cdata0 = 9'(v);
    din0 = {9'(a), 9'(a)}; s0 = 1;
    tick;
    cwe0 = 0; s0 = 0;
    c0[0] = v; push0(a, a);
    finish0("same", 0);
    chk("same_c0", r0, ref0(0));
    chk("same_c1", r1, ref0(1));

    // Overrun, with ovf_clr on the same edge: set wins.
    start0(rnd9(), rnd9());
    repeat (9) tick;
    s0 = 1; din0 = {9'(77), 9'(55)}; oclr0 = 1;
    tick;
    s0 = 0; oclr0 = 0;
    chk("ovf_set", ovf0, 1);
    finish0("ovr", 10);
    chk("ovr_c0", r0, ref0(0));
    chk("ovr_c1", r1, ref0(1));
    oclr0 = 1; tick; oclr0 = 0;
    chk("ovf_clr", ovf0, 0);
    samp0("ovr_next", rnd9(), rnd9());

    // Coefficient write while busy is dropped.
    start0(rnd9(), rnd9());
    repeat (5) tick;
    cwe0 = 1; caddr0 = 0; cdata0 = 9'((c0[0] == 100) ? 101 : 100);
    tick;
    cwe0 = 0;
    chk("cd_set", cd0, 1);
    finish0("cd", 6);
    chk("cd_c0", r0, ref0(0));
    chk("cd_c1", r1, ref0(1));
    oclr0 = 1; tick; oclr0 = 0;
    chk("cd_clr", cd0, 0);
    wc0(40, 77);
    chk("addr40_cd", cd0, 0);
    samp0("addr40", 1 + int'($urandom_range(254)), rnd9());

    // Saturation in both directions.
    for (int k = 0; k < 37; k++) wc0(k, 255);
    for (int n = 0; n < 73; n++) samp0("satp", 255, 255);
    chk("satp_c0", r0, 524287);
    chk("satp_c1", r1, 524287);
    for (int n = 0; n < 73; n++) samp0("satn", -256, -256);
    chk("satn_c0", r0, -524288);
    chk("satn_c1", r1, -524288);

    // Reset mid-run with ovf pending.
    start0(100, 100);
    repeat (9) tick;
    s0 = 1; tick; s0 = 0;
    repeat (10) tick;
    #2 rst_n = 0;
    #1;
    chk("mrst_busy", busy0, 0);
    chk("mrst_dout", longint'(dout0), 0);
    chk("mrst_so", so0, 0);
    chk("mrst_ovf", ovf0, 0);
    chk("mrst_cd", cd0, 0);
    @(posedge clk); #1 rst_n = 1;
    clr_model0();
    sc = 0;
    for (int n = 0; n < 100; n++) begin tick; sc += so0; end
    chk("mrst_nopulse", sc, 0);
    for (int k = 0; k < 37; k++) wc0(k, k + 1);
    for (int n = 0; n < 5; n++) begin
      start0(tbl[n].d0, tbl[n].d1);
      finish0("post", 0);
      chk("post_c0", r0, tbl[n].e0);
      chk("post_c1", r1, tbl[n].e1);
    end

    // Pointer wrap on the 3-channel, 15-tap instance.
    for (int c = 0; c < 3; c++) for (int i = 0; i < 15; i++) x1[c][i] = 0;
    for (int n = 0; n < 300; n++) begin
      if (n % 100 == 0) for (int k = 0; k < 8; k++) wc1(k, rnd9());
      samp1(rnd9(), rnd9(), rnd9());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
